psum_diff_encoder: RTL and testbench

PSUM_DIFF_ENCODER -- requirements
Module: psum_diff_encoder

---
 rtl/diff_core_pkg.sv | 28 ++
 rtl/psum_ref_buf.sv | 42 ++++
 rtl/psum_diff_encoder.sv | 127 ++++++++++++
 tb/tb_psum_diff_encoder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/diff_core_pkg.sv
// rtl/diff_core_pkg.sv - shared width, state type and modular psum arithmetic
//
// Purpose: common definitions for the psum delta encoder slice.
//   PSUM_WIDTH : width of partial sums and deltas
//   state_t    : frame tracking state {IDLE, ACTIVE}
//   psum_add   : the psum adder that reconstructs a psum from ref + delta
//   psum_sub   : the matching modular subtractor used by the encoder
package diff_core_pkg;

  localparam int PSUM_WIDTH = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Both wrap modulo 2^PSUM_WIDTH, so psum_add(r, psum_sub(p, r)) == p always.
  function automatic logic [PSUM_WIDTH-1:0] psum_add(input logic [PSUM_WIDTH-1:0] a,
                                                    input logic [PSUM_WIDTH-1:0] b);
    return a + b;
  endfunction

  function automatic logic [PSUM_WIDTH-1:0] psum_sub(input logic [PSUM_WIDTH-1:0] a,
                                                    input logic [PSUM_WIDTH-1:0] b);
    return a - b;
  endfunction

endpackage

// File: rtl/psum_ref_buf.sv
// rtl/psum_ref_buf.sv - register file holding the last psum per entry
//
// Purpose: DEPTH x PSUM_WIDTH reference store.
// Ports:
//   clk     : clock, rising edge
//   i_clr   : synchronous clear of every entry to zero (has priority)
//   i_we    : write enable
//   i_waddr : write index
//   i_wdata : write data
//   i_raddr : read index
//   o_rdata : combinational read data (a write lands on the edge, so a read
//             in the following cycle already returns the new value)
module psum_ref_buf
  import diff_core_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_clr,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [PSUM_WIDTH-1:0] i_wdata,
  input  logic [ADDR_W-1:0]     i_raddr,
  output logic [PSUM_WIDTH-1:0] o_rdata
);

  logic [PSUM_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/psum_diff_encoder.sv
// rtl/psum_diff_encoder.sv - delta encoder of psums against a per-entry reference
//
// Purpose: for each accepted beat emit in_psum - ref[in_addr] (ref = 0 on the
// first beat of a frame), then store in_psum as the new reference. One-cycle
// latency through a single output register with valid/ready on both sides.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid/in_ready        : input handshake
//   in_psum, in_addr         : partial sum and its reference index
//   in_first, in_last        : frame delimiters
//   skip_zero                : drop zero deltas except on the last beat
//   out_valid/out_ready      : output handshake
//   out_diff,out_addr,out_last : registered delta beat
//   frame_nz_cnt             : beats emitted in the current/last frame
//   active                   : high while inside a frame
module psum_diff_encoder
  import diff_core_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PSUM_WIDTH-1:0] in_psum,
  input  logic [ADDR_W-1:0]     in_addr,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic                  skip_zero,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PSUM_WIDTH-1:0] out_diff,
  output logic [ADDR_W-1:0]     out_addr,
  output logic                  out_last,
  output logic [ADDR_W:0]       frame_nz_cnt,
  output logic                  active
);

  state_t r_state;
  state_t w_state_nxt;

  logic                  r_out_valid;
  logic [PSUM_WIDTH-1:0] r_out_diff;
  logic [ADDR_W-1:0]     r_out_addr;
  logic                  r_out_last;
  logic [ADDR_W:0]       r_cnt;

  logic                  w_accept;
  logic                  w_emit;
  logic [PSUM_WIDTH-1:0] w_rd_data;
  logic [PSUM_WIDTH-1:0] w_ref;
  logic [PSUM_WIDTH-1:0] w_diff;

  psum_ref_buf #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ref_buf (
    .clk     (clk),
    .i_clr   (rst),
    .i_we    (w_accept),
    .i_waddr (in_addr),
    .i_wdata (in_psum),
    .i_raddr (in_addr),
    .o_rdata (w_rd_data)
  );

  // The output slot is free when empty or being drained this same cycle.
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_ref    = in_first ? '0 : w_rd_data;
  assign w_diff   = psum_sub(in_psum, w_ref);
  // A suppressed beat still updates the reference; only its output is dropped.
  assign w_emit   = !(skip_zero && (w_diff == '0) && !in_last);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept && in_first && !in_last) w_state_nxt = ACTIVE;
      ACTIVE:  if (w_accept && in_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_diff  <= '0;
      r_out_addr  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_accept && w_emit) begin
      // Also covers the drain-and-refill cycle: valid stays high with new data.
      r_out_valid <= 1'b1;
      r_out_diff  <= w_diff;
      r_out_addr  <= in_addr;
      r_out_last  <= in_last;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_accept && in_first) begin
      r_cnt <= w_emit ? (ADDR_W+1)'(1) : '0;
    end else if (w_accept && w_emit) begin
      r_cnt <= r_cnt + (ADDR_W+1)'(1);
    end
  end

  assign out_valid    = r_out_valid;
  assign out_diff     = r_out_diff;
  assign out_addr     = r_out_addr;
  assign out_last     = r_out_last;
  assign frame_nz_cnt = r_cnt;
  assign active       = (r_state == ACTIVE);

endmodule

// File: tb/tb_psum_diff_encoder.sv
// tb/tb_psum_diff_encoder.sv - directed self-checking bench for psum_diff_encoder
module tb_psum_diff_encoder;
  import diff_core_pkg::*;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = $clog2(DEPTH);

  logic                  clk;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [PSUM_WIDTH-1:0] in_psum;
  logic [ADDR_W-1:0]     in_addr;
  logic                  in_first;
  logic                  in_last;
  logic                  skip_zero;
  logic                  out_valid;
  logic                  out_ready;
  logic [PSUM_WIDTH-1:0] out_diff;
  logic [ADDR_W-1:0]     out_addr;
  logic                  out_last;
  logic [ADDR_W:0]       frame_nz_cnt;
  logic                  active;

  int checks = 0;
  int errors = 0;
  logic [PSUM_WIDTH-1:0] xfer_q[$];

  psum_diff_encoder #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_psum      (in_psum),
    .in_addr      (in_addr),
    .in_first     (in_first),
    .in_last      (in_last),
    .skip_zero    (skip_zero),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_diff     (out_diff),
    .out_addr     (out_addr),
    .out_last     (out_last),
    .frame_nz_cnt (frame_nz_cnt),
    .active       (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every completed output transfer.
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) xfer_q.push_back(out_diff);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int addr, input int psum, input logic first, input logic last);
    int n;
    in_valid = 1'b1;
    in_addr  = ADDR_W'(addr);
    in_psum  = PSUM_WIDTH'(psum);
    in_first = first;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) check_eq("in_ready_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_psum = '0; in_addr = '0;
    in_first = 1'b0; in_last = 1'b0; skip_zero = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_diff", 32'(out_diff), 32'd0);
    check_eq("rst_cnt", 32'(frame_nz_cnt), 32'd0);
    check_eq("rst_active", 32'(active), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);

    // Two beats at addr 3: first -> 100, then 130 -> 30.
    beat(3, 100, 1'b1, 1'b0);
    check_eq("f1_valid", 32'(out_valid), 32'd1);
    check_eq("f1_diff", 32'(out_diff), 32'd100);
    check_eq("f1_addr", 32'(out_addr), 32'd3);
    check_eq("f1_active", 32'(active), 32'd1);
    check_eq("f1_cnt", 32'(frame_nz_cnt), 32'd1);
    beat(3, 130, 1'b0, 1'b1);
    check_eq("f2_diff", 32'(out_diff), 32'd30);
    check_eq("f2_last", 32'(out_last), 32'd1);
    check_eq("f2_active", 32'(active), 32'd0);
    check_eq("f2_cnt", 32'(frame_nz_cnt), 32'd2);

    // Single first+last beat stays IDLE; negative delta wraps.
    beat(4, 5, 1'b1, 1'b1);
    check_eq("fl_active", 32'(active), 32'd0);
    check_eq("fl_diff", 32'(out_diff), 32'd5);
    check_eq("fl_cnt", 32'(frame_nz_cnt), 32'd1);
    beat(4, 2, 1'b0, 1'b1);
    check_eq("wrap_diff", 32'(out_diff), 32'hFFFD);
    check_eq("wrap_adder", 32'(psum_add(16'd5, out_diff)), 32'd2);

    // Back-to-back at addr 9 (reference 0 since reset).
    beat(9, 10, 1'b0, 1'b0);
    check_eq("b2b_diff0", 32'(out_diff), 32'd10);
    beat(9, 15, 1'b0, 1'b0);
    check_eq("b2b_valid", 32'(out_valid), 32'd1);
    check_eq("b2b_diff1", 32'(out_diff), 32'd5);

    // Zero skip: deltas 0, 7, 0, 0(last) at addr 20.
    skip_zero = 1'b1;
    beat(20, 0, 1'b1, 1'b0);
    check_eq("sz_b0_valid", 32'(out_valid), 32'd0);
    check_eq("sz_b0_active", 32'(active), 32'd1);
    check_eq("sz_b0_cnt", 32'(frame_nz_cnt), 32'd0);
    beat(20, 7, 1'b0, 1'b0);
    check_eq("sz_b1_valid", 32'(out_valid), 32'd1);
    check_eq("sz_b1_diff", 32'(out_diff), 32'd7);
    beat(20, 7, 1'b0, 1'b0);
    check_eq("sz_b2_valid", 32'(out_valid), 32'd0);
    beat(20, 7, 1'b0, 1'b1);
    check_eq("sz_b3_valid", 32'(out_valid), 32'd1);
    check_eq("sz_b3_diff", 32'(out_diff), 32'd0);
    check_eq("sz_b3_last", 32'(out_last), 32'd1);
    check_eq("sz_cnt", 32'(frame_nz_cnt), 32'd2);
    skip_zero = 1'b0;
    tick();

    // Backpressure: hold out_ready low for 5 cycles with a beat waiting.
    xfer_q.delete();
    out_ready = 1'b0;
    beat(30, 50, 1'b1, 1'b0);
    check_eq("st_diff", 32'(out_diff), 32'd50);
    in_valid = 1'b1; in_addr = 6'd31; in_psum = 16'd60; in_first = 1'b0; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("st_in_ready", 32'(in_ready), 32'd0);
      check_eq("st_hold_valid", 32'(out_valid), 32'd1);
      check_eq("st_hold_diff", 32'(out_diff), 32'd50);
      check_eq("st_hold_addr", 32'(out_addr), 32'd30);
    end
    out_ready = 1'b1;
    #1;
    check_eq("st_release_ready", 32'(in_ready), 32'd1);
    tick();
    check_eq("st_refill_valid", 32'(out_valid), 32'd1);
    check_eq("st_refill_diff", 32'(out_diff), 32'd60);
    in_addr = 6'd32; in_psum = 16'd70; in_last = 1'b1;
    tick();
    check_eq("st_c_diff", 32'(out_diff), 32'd70);
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    check_eq("st_drained", 32'(out_valid), 32'd0);
    check_eq("st_xfers", 32'(xfer_q.size()), 32'd3);
    if (xfer_q.size() == 3) begin
      check_eq("st_x0", 32'(xfer_q[0]), 32'd50);
      check_eq("st_x1", 32'(xfer_q[1]), 32'd60);
      check_eq("st_x2", 32'(xfer_q[2]), 32'd70);
    end

    // Reset mid-frame while a beat is stalled in the output register.
    out_ready = 1'b0;
    beat(40, 77, 1'b1, 1'b0);
    check_eq("mr_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    tick();
    check_eq("mr_valid", 32'(out_valid), 32'd0);
    check_eq("mr_diff", 32'(out_diff), 32'd0);
    check_eq("mr_addr", 32'(out_addr), 32'd0);
    check_eq("mr_last", 32'(out_last), 32'd0);
    check_eq("mr_cnt", 32'(frame_nz_cnt), 32'd0);
    check_eq("mr_active", 32'(active), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("mr_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    beat(40, 4, 1'b0, 1'b0);
    check_eq("mr_ref40_clr", 32'(out_diff), 32'd4);
    beat(3, 4, 1'b0, 1'b1);
    check_eq("mr_ref3_clr", 32'(out_diff), 32'd4);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
